// File: rtl/memory_access.sv
// MEM pipeline stage: issues data-memory loads/stores over a req/ack bus,
// stalls upstream while a transaction is outstanding, and registers results for writeback.
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] exec_data_in,
  input  logic [31:0] next_pc,
  input  logic [1:0]  res_src_in,
  output logic        stall,
  output logic        valid_out,
  output logic [31:0] exec_data_out,
  output logic [31:0] mem_data_out,
  output logic [31:0] next_pc_out,
  output logic [1:0]  res_src_out,
  output logic        misaligned_exc,
  output logic        bus_error,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = rd >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = rd;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] r;
    case (f3)
      3'b000:  r = 4'b0001 << lane;
      3'b001:  r = 4'b0011 << lane;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lane_q, lane_d;
  logic [2:0]    f3_q, f3_d;
  logic          load_q, load_d;
  logic [31:0]   hold_exec_q, hold_exec_d;
  logic [31:0]   hold_pc_q, hold_pc_d;
  logic [1:0]    hold_res_q, hold_res_d;
  logic          valid_q, valid_d;
  logic [31:0]   exec_q, exec_d;
  logic [31:0]   mdata_q, mdata_d;
  logic [31:0]   pc_q, pc_d;
  logic [1:0]    res_q, res_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   daddr_q, daddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;

  logic memop_s;
  logic legal_s;
  logic aligned_s;
  logic ok_s;

  assign memop_s = valid_in & (mem_read | mem_write);
  assign ok_s    = legal_s & aligned_s;

  // Access legality: funct3 encoding and natural alignment for the access size.
  always_comb begin
    legal_s   = 1'b0;
    aligned_s = 1'b1;
    if (mem_read) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
        default:                                legal_s = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal_s = 1'b1;
        default:                legal_s = 1'b0;
      endcase
    end
    case (funct3[1:0])
      2'b01:   aligned_s = ~addr[0];
      2'b10:   aligned_s = (addr[1:0] == 2'b00);
      default: aligned_s = 1'b1;
    endcase
  end

  // Next-state logic: issue, wait for ack or timeout, then present results for one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    f3_d        = f3_q;
    load_d      = load_q;
    hold_exec_d = hold_exec_q;
    hold_pc_d   = hold_pc_q;
    hold_res_d  = hold_res_q;
    valid_d     = 1'b0;
    exec_d      = exec_q;
    mdata_d     = mdata_q;
    pc_d        = pc_q;
    res_d       = res_q;
    mis_d       = 1'b0;
    berr_d      = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    daddr_d     = daddr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    case (state_q)
      IDLE: begin
        if (memop_s && ok_s) begin
          state_d     = BUSY;
          cnt_d       = {CW{1'b0}};
          lane_d      = addr[1:0];
          f3_d        = funct3;
          load_d      = mem_read;
          hold_exec_d = exec_data_in;
          hold_pc_d   = next_pc;
          hold_res_d  = res_src_in;
          req_d       = 1'b1;
          we_d        = ~mem_read;
          daddr_d     = {addr[31:2], 2'b00};
          be_d        = mem_read ? 4'b1111 : store_be(funct3, addr[1:0]);
          wdata_d     = mem_read ? 32'h0000_0000 : store_wdata(funct3, store_data);
        end else if (valid_in) begin
          // Non-memory op or rejected access: retire in one cycle, no bus activity.
          valid_d = 1'b1;
          mis_d   = memop_s;
          exec_d  = exec_data_in;
          pc_d    = next_pc;
          res_d   = res_src_in;
          mdata_d = 32'h0000_0000;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          exec_d  = hold_exec_q;
          pc_d    = hold_pc_q;
          res_d   = hold_res_q;
          mdata_d = load_q ? load_extract(f3_q, lane_q, dmem_rdata) : 32'h0000_0000;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          berr_d  = 1'b1;
          exec_d  = hold_exec_q;
          pc_d    = hold_pc_q;
          res_d   = hold_res_q;
          mdata_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      lane_q      <= 2'b00;
      f3_q        <= 3'b000;
      load_q      <= 1'b0;
      hold_exec_q <= 32'h0000_0000;
      hold_pc_q   <= 32'h0000_0000;
      hold_res_q  <= 2'b00;
      valid_q     <= 1'b0;
      exec_q      <= 32'h0000_0000;
      mdata_q     <= 32'h0000_0000;
      pc_q        <= 32'h0000_0000;
      res_q       <= 2'b00;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      daddr_q     <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      f3_q        <= f3_d;
      load_q      <= load_d;
      hold_exec_q <= hold_exec_d;
      hold_pc_q   <= hold_pc_d;
      hold_res_q  <= hold_res_d;
      valid_q     <= valid_d;
      exec_q      <= exec_d;
      mdata_q     <= mdata_d;
      pc_q        <= pc_d;
      res_q       <= res_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
      req_q       <= req_d;
      we_q        <= we_d;
      daddr_q     <= daddr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  assign stall          = (state_q == BUSY) | ((state_q == IDLE) & memop_s & ok_s);
  assign valid_out      = valid_q;
  assign exec_data_out  = exec_q;
  assign mem_data_out   = mdata_q;
  assign next_pc_out    = pc_q;
  assign res_src_out    = res_q;
  assign misaligned_exc = mis_q;
  assign bus_error      = berr_q;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = daddr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;

endmodule
